// File: rtl/mips_multi_cycle.sv
// Multi-cycle MIPS32-subset core: five-state control unit, datapath,
// unified instruction/data memory and one memory-mapped 8-bit output port.

// Control unit: sequences IF/ID/EX/MA/WB, skipping states an instruction does not need.
module mips_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic       op_known,
    input  logic       op_wb,
    input  logic       op_mem,
    input  logic       op_lw,
    output logic [2:0] state
);
    typedef enum logic [2:0] {
        S_IF = 3'd0,
        S_ID = 3'd1,
        S_EX = 3'd2,
        S_MA = 3'd3,
        S_WB = 3'd4
    } state_t;

    state_t STATE;
    state_t next_state;

    assign state = STATE;

    // State register, cleared asynchronously so a reset aborts the instruction at once
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) STATE <= S_IF;
        else        STATE <= next_state;
    end

    // Next-state selection from the decoded opcode class; illegal codes fall back to IF
    always_comb begin
        next_state = S_IF;
        case (STATE)
            S_IF: next_state = S_ID;
            S_ID: next_state = op_known ? S_EX : S_IF;
            S_EX: begin
                if (op_wb)       next_state = S_WB;
                else if (op_mem) next_state = S_MA;
                else             next_state = S_IF;
            end
            S_MA:    next_state = op_lw ? S_WB : S_IF;
            S_WB:    next_state = S_IF;
            default: next_state = S_IF;
        endcase
    end
endmodule

// Top-level CPU: datapath registers, register file, memory and GPIO.
module mips_multi_cycle #(
    parameter int          MEM_DEPTH = 256,
    parameter string       MEM_FILE  = "program.hex",
    parameter logic [31:0] GPIO_ADDR = 32'h0000_0400
) (
    input  logic       clk,
    input  logic       reset,
    output logic [7:0] GPIO_o
);
    localparam int AW = $clog2(MEM_DEPTH);

    localparam logic [2:0] ST_IF = 3'd0;
    localparam logic [2:0] ST_ID = 3'd1;
    localparam logic [2:0] ST_EX = 3'd2;
    localparam logic [2:0] ST_MA = 3'd3;
    localparam logic [2:0] ST_WB = 3'd4;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_SLTI = 6'h0A;
    localparam logic [5:0] OP_ANDI = 6'h0C;
    localparam logic [5:0] OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_LUI  = 6'h0F;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

    logic [31:0] mem [MEM_DEPTH];
    logic [31:0] rf  [32];
    logic [31:0] pc, ir, a, b, alu_out, mdr;
    logic [2:0]  state;

    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [25:0] target;
    logic [31:0] imm_sext, imm_zext, rs_val, rt_val;
    logic [31:0] fetch_word, load_word, ex_result, wb_val;
    logic        is_r, is_alui, is_lw, is_sw, is_beq, is_bne, is_j;
    logic        op_known, funct_ok, is_gpio, wb_en;
    logic [4:0]  wb_idx;

    // Only word addresses below MEM_DEPTH reach the array; everything else reads 0
    function automatic logic in_mem(input logic [31:0] addr);
        return {2'b00, addr[31:2]} < 32'(MEM_DEPTH);
    endfunction

    function automatic logic [AW-1:0] word_idx(input logic [31:0] addr);
        return addr[AW+1:2];
    endfunction

    assign opcode   = ir[31:26];
    assign rs       = ir[25:21];
    assign rt       = ir[20:16];
    assign rd       = ir[15:11];
    assign funct    = ir[5:0];
    assign imm      = ir[15:0];
    assign target   = ir[25:0];
    assign imm_sext = {{16{imm[15]}}, imm};
    assign imm_zext = {16'h0, imm};

    assign is_r     = (opcode == OP_R);
    assign is_alui  = (opcode == OP_ADDI) || (opcode == OP_SLTI) || (opcode == OP_ANDI) ||
                      (opcode == OP_ORI)  || (opcode == OP_LUI);
    assign is_lw    = (opcode == OP_LW);
    assign is_sw    = (opcode == OP_SW);
    assign is_beq   = (opcode == OP_BEQ);
    assign is_bne   = (opcode == OP_BNE);
    assign is_j     = (opcode == OP_J);
    assign op_known = is_r || is_alui || is_lw || is_sw || is_beq || is_bne || is_j;
    assign funct_ok = funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_NOR, FN_SLT};

    // $0 is hard-wired to zero on the read side
    assign rs_val = (rs == 5'd0) ? 32'h0 : rf[rs];
    assign rt_val = (rt == 5'd0) ? 32'h0 : rf[rt];

    assign is_gpio    = (alu_out[31:2] == GPIO_ADDR[31:2]);
    assign fetch_word = in_mem(pc) ? mem[word_idx(pc)] : 32'h0;
    assign load_word  = is_gpio ? {24'h0, GPIO_o}
                                : (in_mem(alu_out) ? mem[word_idx(alu_out)] : 32'h0);

    mips_ctrl UC_U15 (
        .clk      (clk),
        .reset    (reset),
        .op_known (op_known),
        .op_wb    (is_r || is_alui),
        .op_mem   (is_lw || is_sw),
        .op_lw    (is_lw),
        .state    (state)
    );

    // EX-stage ALU: operand selection and operation come straight from the opcode/funct
    always_comb begin
        ex_result = 32'h0;
        case (opcode)
            OP_R: begin
                case (funct)
                    FN_ADD:  ex_result = a + b;
                    FN_SUB:  ex_result = a - b;
                    FN_AND:  ex_result = a & b;
                    FN_OR:   ex_result = a | b;
                    FN_NOR:  ex_result = ~(a | b);
                    FN_SLT:  ex_result = {31'h0, $signed(a) < $signed(b)};
                    default: ex_result = 32'h0;
                endcase
            end
            OP_ADDI:      ex_result = a + imm_sext;
            OP_SLTI:      ex_result = {31'h0, $signed(a) < $signed(imm_sext)};
            OP_ANDI:      ex_result = a & imm_zext;
            OP_ORI:       ex_result = a | imm_zext;
            OP_LUI:       ex_result = {imm, 16'h0};
            OP_LW, OP_SW: ex_result = a + imm_sext;
            default:      ex_result = 32'h0;
        endcase
    end

    // Writeback target: rd for R-type, rt for I-type and loads; unknown funct writes nothing
    always_comb begin
        wb_en  = 1'b0;
        wb_idx = rt;
        wb_val = alu_out;
        if (state == ST_WB) begin
            if (is_r) begin
                wb_en  = funct_ok;
                wb_idx = rd;
            end else if (is_alui) begin
                wb_en  = 1'b1;
            end else if (is_lw) begin
                wb_en  = 1'b1;
                wb_val = mdr;
            end
        end
    end

    // Register file: cleared on reset, writes to $0 discarded
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) rf[i] <= 32'h0;
        end else if (wb_en && (wb_idx != 5'd0)) begin
            rf[wb_idx] <= wb_val;
        end
    end

    // Datapath registers, each updated only in the state that owns it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc      <= 32'h0;
            ir      <= 32'h0;
            a       <= 32'h0;
            b       <= 32'h0;
            alu_out <= 32'h0;
            mdr     <= 32'h0;
            GPIO_o  <= 8'h0;
        end else begin
            case (state)
                ST_IF: begin
                    ir <= fetch_word;
                    pc <= pc + 32'd4;
                end
                ST_ID: begin
                    a       <= rs_val;
                    b       <= rt_val;
                    alu_out <= pc + {imm_sext[29:0], 2'b00};
                end
                ST_EX: begin
                    if (is_r || is_alui || is_lw || is_sw) alu_out <= ex_result;
                    if ((is_beq && (a == b)) || (is_bne && (a != b))) pc <= alu_out;
                    if (is_j) pc <= {pc[31:28], target, 2'b00};
                end
                ST_MA: begin
                    if (is_lw) mdr <= load_word;
                    if (is_sw && is_gpio) GPIO_o <= b[7:0];
                end
                default: ;
            endcase
        end
    end

    // Memory write port; contents survive reset, out-of-range stores are dropped
    always_ff @(posedge clk) begin
        if ((state == ST_MA) && is_sw && !is_gpio && in_mem(alu_out))
            mem[word_idx(alu_out)] <= b;
    end
endmodule

// File: tb/tb_mips_multi_cycle.sv
// Directed bench for mips_multi_cycle: an instruction-level reference model predicts
// the per-cycle control state and GPIO value; literal checks pin key cycles.
module tb_mips_multi_cycle;
    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_SLTI = 6'h0A;
    localparam logic [5:0] OP_ANDI = 6'h0C;
    localparam logic [5:0] OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_LUI  = 6'h0F;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam int MAXC = 64;

    logic       clk;
    logic       reset;
    logic [7:0] GPIO_o;

    mips_multi_cycle #(
        .MEM_DEPTH (256),
        .MEM_FILE  (""),
        .GPIO_ADDR (32'h0000_0400)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .GPIO_o (GPIO_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int ncyc_cur = 0;
    logic checking = 1'b0;
    logic [2:0]  st;
    logic [31:0] prog [$];
    logic [31:0] mmem [256];
    logic [2:0]  exp_state [MAXC];
    logic [7:0]  exp_gpio  [MAXC];
    logic [2:0]  act_state [MAXC];
    logic [7:0]  act_gpio  [MAXC];

    function automatic logic [31:0] ei(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] er(input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [4:0] rd, input logic [5:0] fn);
        return {OP_R, rs, rt, rd, 5'h0, fn};
    endfunction

    task automatic check(input string nm, input int c, input logic [31:0] act,
                         input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s cyc=%0d actual=0x%0h required=0x%0h", nm, c, act, req);
        end
    endtask

    // Instruction-level model: executes each instruction whole and expands it
    // into the list of control states it occupies, one per clock.
    task automatic build_model(input int ncyc);
        logic [31:0] r [32];
        logic [31:0] pc, ir, pc4, se, ze, rsv, rtv, res, addr, nxt;
        logic [2:0]  sq [5];
        logic [7:0]  g, gv;
        logic [4:0]  wi;
        logic        wr, gw, mw;
        int n, p;
        for (int i = 0; i < 32; i++) r[i] = 32'h0;
        pc = 32'h0; g = 8'h0; p = 0;
        while (p < ncyc) begin
            ir  = (pc < 32'd1024) ? mmem[pc[9:2]] : 32'h0;
            pc4 = pc + 32'd4;
            nxt = pc4;
            se  = {{16{ir[15]}}, ir[15:0]};
            ze  = {16'h0, ir[15:0]};
            rsv = r[ir[25:21]];
            rtv = r[ir[20:16]];
            addr = rsv + se;
            wr = 1'b0; wi = ir[20:16]; res = 32'h0; gw = 1'b0; gv = 8'h0; mw = 1'b0;
            sq[0] = 3'd0; sq[1] = 3'd1; sq[2] = 3'd2; sq[3] = 3'd4; sq[4] = 3'd0;
            n = 4;
            case (ir[31:26])
                OP_R: begin
                    wi = ir[15:11];
                    wr = 1'b1;
                    case (ir[5:0])
                        6'h20:   res = rsv + rtv;
                        6'h22:   res = rsv - rtv;
                        6'h24:   res = rsv & rtv;
                        6'h25:   res = rsv | rtv;
                        6'h27:   res = ~(rsv | rtv);
                        6'h2A:   res = ($signed(rsv) < $signed(rtv)) ? 32'd1 : 32'd0;
                        default: wr = 1'b0;
                    endcase
                end
                OP_ADDI: begin wr = 1'b1; res = rsv + se; end
                OP_SLTI: begin wr = 1'b1; res = ($signed(rsv) < $signed(se)) ? 32'd1 : 32'd0; end
                OP_ANDI: begin wr = 1'b1; res = rsv & ze; end
                OP_ORI:  begin wr = 1'b1; res = rsv | ze; end
                OP_LUI:  begin wr = 1'b1; res = {ir[15:0], 16'h0}; end
                OP_LW: begin
                    n = 5; sq[3] = 3'd3; sq[4] = 3'd4; wr = 1'b1;
                    if (addr[31:2] == 30'h100) res = {24'h0, g};
                    else if (addr < 32'd1024)  res = mmem[addr[9:2]];
                    else                       res = 32'h0;
                end
                OP_SW: begin
                    sq[3] = 3'd3;
                    if (addr[31:2] == 30'h100) begin gw = 1'b1; gv = rtv[7:0]; end
                    else if (addr < 32'd1024) mw = 1'b1;
                end
                OP_BEQ: begin n = 3; if (rsv == rtv) nxt = pc4 + {se[29:0], 2'b00}; end
                OP_BNE: begin n = 3; if (rsv != rtv) nxt = pc4 + {se[29:0], 2'b00}; end
                OP_J:   begin n = 3; nxt = {pc4[31:28], ir[25:0], 2'b00}; end
                default: n = 2;
            endcase
            for (int s = 0; s < n; s++) begin
                if (p < ncyc) begin
                    exp_state[p] = sq[s];
                    exp_gpio[p]  = g;
                    p++;
                    if ((sq[s] == 3'd3) && gw) g = gv;
                end
            end
            if (wr && (wi != 5'd0)) r[wi] = res;
            if (mw) mmem[addr[9:2]] = rtv;
            pc = nxt;
        end
    endtask

    // Per-cycle comparison of the control state and GPIO against the model
    always @(negedge clk) begin
        if (checking && (cyc < ncyc_cur)) begin
            st = dut.UC_U15.STATE;
            act_state[cyc] = st;
            act_gpio[cyc]  = GPIO_o;
            check("state", cyc, {29'h0, st}, {29'h0, exp_state[cyc]});
            check("gpio", cyc, {24'h0, GPIO_o}, {24'h0, exp_gpio[cyc]});
            cyc++;
        end
    end

    // Hold reset and load the program into both the DUT memory and the model copy
    task automatic prep();
        logic [31:0] w;
        reset = 1'b0;
        #1;
        for (int i = 0; i < 256; i++) begin
            w = (i < prog.size()) ? prog[i] : 32'h0;
            mmem[i] = w;
            dut.mem[i] = w;
        end
    endtask

    task automatic start(input int n);
        ncyc_cur = n;
        cyc = 0;
        build_model(n);
        @(posedge clk);
        #1 reset = 1'b1;
        checking = 1'b1;
    endtask

    task automatic run(input int n);
        int guard;
        start(n);
        guard = 0;
        while ((cyc < n) && (guard < n + 10)) begin
            @(posedge clk);
            guard++;
        end
        check("cycles_done", guard, cyc, n);
        checking = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        #1;
        // Arithmetic to GPIO
        prog.delete();
        prog.push_back(ei(OP_ADDI, 5'd0, 5'd8, 16'd5));
        prog.push_back(ei(OP_ADDI, 5'd8, 5'd9, 16'd3));
        prog.push_back(er(5'd8, 5'd9, 5'd10, 6'h20));
        prog.push_back(ei(OP_SW, 5'd0, 5'd10, 16'h0400));
        prep();
        #2;
        check("rst_state", 0, {29'h0, dut.UC_U15.STATE}, 32'd0);
        check("rst_gpio", 0, {24'h0, GPIO_o}, 32'd0);
        check("rst_pc", 0, dut.pc, 32'd0);
        run(30);
        check("arith_st0", 0, {29'h0, act_state[0]}, 32'd0);
        check("arith_st1", 1, {29'h0, act_state[1]}, 32'd1);
        check("arith_st2", 2, {29'h0, act_state[2]}, 32'd2);
        check("arith_st3", 3, {29'h0, act_state[3]}, 32'd4);
        check("arith_st4", 4, {29'h0, act_state[4]}, 32'd0);
        check("arith_gpio15", 15, {24'h0, act_gpio[15]}, 32'h00);
        check("arith_gpio16", 16, {24'h0, act_gpio[16]}, 32'h0D);

        // Load/store through memory and GPIO read-back
        prog.delete();
        prog.push_back(ei(OP_LUI, 5'd0, 5'd1, 16'hDEAD));
        prog.push_back(ei(OP_ORI, 5'd1, 5'd1, 16'hBEEF));
        prog.push_back(ei(OP_SW, 5'd0, 5'd1, 16'h0040));
        prog.push_back(ei(OP_LW, 5'd0, 5'd11, 16'h0040));
        prog.push_back(ei(OP_SW, 5'd0, 5'd11, 16'h0400));
        prog.push_back(ei(OP_LW, 5'd0, 5'd12, 16'h0400));
        prog.push_back(ei(OP_ADDI, 5'd12, 5'd12, 16'd1));
        prog.push_back(ei(OP_SW, 5'd0, 5'd12, 16'h0400));
        prep();
        check("rst_rf8", 0, dut.rf[8], 32'd0);
        check("rst_gpio2", 0, {24'h0, GPIO_o}, 32'd0);
        run(40);
        check("lw_ma", 15, {29'h0, act_state[15]}, 32'd3);
        check("lw_wb", 16, {29'h0, act_state[16]}, 32'd4);
        check("ls_gpio20", 20, {24'h0, act_gpio[20]}, 32'h00);
        check("ls_gpio21", 21, {24'h0, act_gpio[21]}, 32'hEF);
        check("ls_gpio34", 34, {24'h0, act_gpio[34]}, 32'hF0);
        check("ls_mem", 0, dut.mem[16], 32'hDEADBEEF);

        // Branches and jump
        prog.delete();
        prog.push_back(ei(OP_ADDI, 5'd4, 5'd4, 16'd1));
        prog.push_back(ei(OP_ADDI, 5'd0, 5'd2, 16'h00FF));
        prog.push_back(ei(OP_BEQ, 5'd0, 5'd0, 16'd1));
        prog.push_back(ei(OP_SW, 5'd0, 5'd2, 16'h0400));
        prog.push_back(ei(OP_BNE, 5'd0, 5'd0, 16'd1));
        prog.push_back(ei(OP_SW, 5'd0, 5'd4, 16'h0400));
        prog.push_back({OP_J, 26'h0});
        prep();
        run(45);
        check("beq_ex", 10, {29'h0, act_state[10]}, 32'd2);
        check("beq_3st", 11, {29'h0, act_state[11]}, 32'd0);
        check("br_gpio18", 18, {24'h0, act_gpio[18]}, 32'h01);
        check("j_gpio39", 39, {24'h0, act_gpio[39]}, 32'h02);

        // $0 behaviour, signed compare, logic ops, unknown opcode
        prog.delete();
        prog.push_back(ei(OP_ADDI, 5'd0, 5'd7, 16'h005A));
        prog.push_back(ei(OP_SW, 5'd0, 5'd7, 16'h0400));
        prog.push_back(ei(OP_ADDI, 5'd0, 5'd0, 16'd7));
        prog.push_back(ei(OP_SW, 5'd0, 5'd0, 16'h0400));
        prog.push_back(ei(OP_ADDI, 5'd0, 5'd5, 16'hFFFF));
        prog.push_back(ei(OP_SLTI, 5'd5, 5'd6, 16'd0));
        prog.push_back(ei(OP_SW, 5'd0, 5'd6, 16'h0400));
        prog.push_back(er(5'd6, 5'd5, 5'd9, 6'h22));
        prog.push_back(er(5'd9, 5'd0, 5'd10, 6'h27));
        prog.push_back(ei(OP_ANDI, 5'd10, 5'd11, 16'hF0F0));
        prog.push_back(ei(OP_SW, 5'd0, 5'd11, 16'h0400));
        prog.push_back(32'hFC00_0000);
        prog.push_back(ei(OP_SW, 5'd0, 5'd9, 16'h0400));
        prep();
        run(56);
        check("z_gpio8", 8, {24'h0, act_gpio[8]}, 32'h5A);
        check("z_gpio16", 16, {24'h0, act_gpio[16]}, 32'h00);
        check("slti_gpio28", 28, {24'h0, act_gpio[28]}, 32'h01);
        check("logic_gpio44", 44, {24'h0, act_gpio[44]}, 32'hF0);
        check("unk_id", 45, {29'h0, act_state[45]}, 32'd1);
        check("unk_2st", 46, {29'h0, act_state[46]}, 32'd0);
        check("sub_gpio50", 50, {24'h0, act_gpio[50]}, 32'h02);

        // Reset asserted during the sw's EX state
        prog.delete();
        prog.push_back(ei(OP_ADDI, 5'd0, 5'd8, 16'd5));
        prog.push_back(ei(OP_SW, 5'd0, 5'd8, 16'h0400));
        prep();
        start(6);
        repeat (6) @(posedge clk);
        #2;
        checking = 1'b0;
        check("mid_cycles", 0, cyc, 6);
        check("mid_ex", 6, {29'h0, dut.UC_U15.STATE}, 32'd2);
        reset = 1'b0;
        #1;
        check("mid_rst_state", 6, {29'h0, dut.UC_U15.STATE}, 32'd0);
        check("mid_rst_pc", 6, dut.pc, 32'd0);
        check("mid_rst_gpio", 6, {24'h0, GPIO_o}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("mid_hold_gpio", 9, {24'h0, GPIO_o}, 32'd0);
        check("mid_hold_state", 9, {29'h0, dut.UC_U15.STATE}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
